// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 8N1 UART receiver with synchronizer, 3-sample majority vote and break recovery
module uart_rx_sampler #(
  parameter int SERIAL_WCNT = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR,
  output logic       BUSY
);

  localparam int H  = SERIAL_WCNT / 2;
  localparam int CW = (SERIAL_WCNT > 2) ? $clog2(SERIAL_WCNT) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SERIAL_WCNT - 1);
  localparam logic [CW-1:0] SMP_EARLY = CW'(H - 1);
  localparam logic [CW-1:0] SMP_MID   = CW'(H);
  localparam logic [CW-1:0] SMP_LATE  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rxd_s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          smp_a;
  logic          smp_b;
  logic          vote;
  logic          decide;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= RXD;
      rxd_s <= sync1;
    end
  end

  // Bit timer wraps every bit period; majority of the two stored samples and the live one
  always_comb begin
    cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
    vote    = (smp_a & smp_b) | (smp_a & rxd_s) | (smp_b & rxd_s);
    decide  = (cnt == SMP_LATE);
  end

  // Receive FSM: cnt is 0 in the cycle the start edge is seen, so every decision
  // lands at cnt == H+1 of its bit period without ever re-aligning the timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      bidx  <= '0;
      shreg <= '0;
      smp_a <= 1'b1;
      smp_b <= 1'b1;
      DATA  <= '0;
      VALID <= 1'b0;
      FERR  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      FERR  <= 1'b0;
      if (cnt == SMP_EARLY) smp_a <= rxd_s;
      if (cnt == SMP_MID)   smp_b <= rxd_s;
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          bidx <= '0;
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= CNT_ONE;
            BUSY  <= 1'b1;
          end
        end
        S_START: begin
          cnt <= cnt_inc;
          if (decide) begin
            if (vote) begin
              state <= S_IDLE;
              cnt   <= '0;
              BUSY  <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          cnt <= cnt_inc;
          if (decide) begin
            shreg <= {vote, shreg[7:1]};
            bidx  <= bidx + 3'd1;
            if (bidx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          cnt <= cnt_inc;
          if (decide) begin
            cnt <= '0;
            if (vote) begin
              DATA  <= shreg;
              VALID <= 1'b1;
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end else begin
              FERR  <= 1'b1;
              state <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rxd_s) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - self-checking bench for uart_rx_sampler
module tb_uart_rx_sampler;

  localparam int W   = 16;
  localparam int LAT = 2 + W / 2 + 2 + 9 * W;  // RXD edge -> VALID: sync + H+2+9W
  localparam int HIST = 16384;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RXD = 1'b1;
  logic [7:0] DATA;
  logic       VALID;
  logic       FERR;
  logic       BUSY;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol = 0;
  bit prev_ev = 1'b0;
  bit busy_hist [0:HIST-1];
  int v_cyc[$];
  logic [7:0] v_dat[$];
  int f_cyc[$];

  uart_rx_sampler #(.SERIAL_WCNT(W)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD),
    .DATA(DATA), .VALID(VALID), .FERR(FERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Cycle index, advanced on each active edge
  always @(posedge CLK) cyc <= cyc + 1;

  // Event log sampled mid-cycle
  always @(negedge CLK) begin
    if (cyc < HIST) busy_hist[cyc] = BUSY;
    if (VALID) begin v_cyc.push_back(cyc); v_dat.push_back(DATA); end
    if (FERR) f_cyc.push_back(cyc);
    if ((VALID && FERR) || ((VALID || FERR) && prev_ev)) viol++;
    prev_ev = VALID || FERR;
  end

  task automatic clear_events();
    v_cyc.delete(); v_dat.delete(); f_cyc.delete();
  endtask

  task automatic hold(input logic val, input int n);
    RXD = val;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Drives one 10-bit frame; glitch inverts RXD for one cycle at that offset (-1 = none)
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch, output int start);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    start = cyc;
    for (int k = 0; k < 10 * W; k++) begin
      RXD = bits[k / W] ^ (k == glitch);
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    checks++; if (DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", DATA); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", VALID); end
    checks++; if (FERR !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", FERR); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    RST = 1'b0;
    hold(1'b1, 5);
  endtask

  task automatic test_single();
    int st;
    bit ok;
    clear_events();
    hold(1'b1, 40);
    send_frame(8'hA5, 1'b1, -1, st);
    hold(1'b1, 20);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++; if (v_dat[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", v_dat[0]); end
      checks++; if (v_cyc[0] !== st + LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", v_cyc[0] - st, LAT); end
    end
    checks++; if (f_cyc.size() !== 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", f_cyc.size()); end
    checks++; if (busy_hist[st + 2] !== 1'b0) begin errors++; $display("FAIL single_busy_t0: got 1 want 0"); end
    ok = 1'b1;
    for (int c = st + 3; c < st + LAT; c++) if (!busy_hist[c]) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL single_busy_frame: got low want high"); end
  endtask

  task automatic test_glitch();
    int st;
    clear_events();
    hold(1'b1, 10);
    st = cyc;
    hold(1'b0, 3);
    hold(1'b1, 30);
    checks++; if (v_cyc.size() !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", v_cyc.size()); end
    checks++; if (f_cyc.size() !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", f_cyc.size()); end
    checks++; if (DATA !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h want a5", DATA); end
    checks++; if (busy_hist[st + 3] !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got 0 want 1"); end
    checks++; if (busy_hist[st + 14] !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got 1 want 0"); end
  endtask

  task automatic test_ferr();
    int st, hl, st2;
    bit ok;
    clear_events();
    hold(1'b1, 10);
    send_frame(8'h3C, 1'b0, -1, st);
    hold(1'b0, 50);
    hl = cyc;
    hold(1'b1, 30);
    checks++; if (f_cyc.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", f_cyc.size()); end
    if (f_cyc.size() >= 1) begin
      checks++; if (f_cyc[0] !== st + LAT) begin errors++; $display("FAIL ferr_latency: got %0d want %0d", f_cyc[0] - st, LAT); end
    end
    checks++; if (v_cyc.size() !== 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", v_cyc.size()); end
    checks++; if (DATA !== 8'hA5) begin errors++; $display("FAIL ferr_data_held: got %h want a5", DATA); end
    ok = 1'b1;
    for (int c = st + 3; c <= hl + 2; c++) if (!busy_hist[c]) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL ferr_busy_break: got low want high"); end
    checks++; if (busy_hist[hl + 3] !== 1'b0) begin errors++; $display("FAIL ferr_busy_recover: got 1 want 0"); end
    clear_events();
    send_frame(8'h5A, 1'b1, -1, st2);
    hold(1'b1, 20);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++; if (v_dat[0] !== 8'h5A) begin errors++; $display("FAIL ferr_next_data: got %h want 5a", v_dat[0]); end
      checks++; if (v_cyc[0] !== st2 + LAT) begin errors++; $display("FAIL ferr_next_latency: got %0d want %0d", v_cyc[0] - st2, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int st[3];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81;
    clear_events();
    hold(1'b1, 10);
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, -1, st[i]);
    hold(1'b1, 20);
    checks++; if (v_cyc.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", v_cyc.size()); end
    for (int i = 0; i < 3 && i < v_cyc.size(); i++) begin
      checks++; if (v_dat[i] !== bytes[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, v_dat[i], bytes[i]); end
      checks++; if (v_cyc[i] !== st[0] + LAT + 10 * W * i) begin errors++; $display("FAIL b2b_time%0d: got %0d want %0d", i, v_cyc[i] - st[0], LAT + 10 * W * i); end
    end
  endtask

  task automatic test_majority();
    int st;
    clear_events();
    hold(1'b1, 10);
    send_frame(8'h55, 1'b1, 4 * W + W / 2, st);
    hold(1'b1, 20);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL maj_count: got %0d want 1", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++; if (v_dat[0] !== 8'h55) begin errors++; $display("FAIL maj_data: got %h want 55", v_dat[0]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] bits;
    int st;
    bit seen;
    bits = {1'b1, 8'h12, 1'b0};
    clear_events();
    hold(1'b1, 10);
    for (int k = 0; k < 10 * W; k++) begin
      RXD = bits[k / W];
      if (k == 5 * W + W / 2) RST = 1'b1;
      @(posedge CLK); #1;
      if (k == 5 * W + W / 2) begin
        RST = 1'b0;
        checks++; if (DATA !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", DATA); end
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", VALID); end
        checks++; if (FERR !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b want 0", FERR); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", BUSY); end
      end
    end
    hold(1'b1, 200);
    seen = 1'b0;
    foreach (v_dat[i]) if (v_dat[i] == 8'h12) seen = 1'b1;
    checks++; if (seen) begin errors++; $display("FAIL midrst_truncated: got valid 12 want none"); end
    clear_events();
    send_frame(8'h34, 1'b1, -1, st);
    hold(1'b1, 20);
    checks++; if (v_cyc.size() !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d want 1", v_cyc.size()); end
    if (v_cyc.size() >= 1) begin
      checks++; if (v_dat[0] !== 8'h34) begin errors++; $display("FAIL midrst_next_data: got %h want 34", v_dat[0]); end
      checks++; if (v_cyc[0] !== st + LAT) begin errors++; $display("FAIL midrst_next_latency: got %0d want %0d", v_cyc[0] - st, LAT); end
    end
  endtask

  // Random bytes, random gaps (including none) and a one-cycle glitch somewhere in the data bits
  task automatic test_random();
    logic [7:0] exp_dat[$];
    int exp_cyc[$];
    logic [7:0] b;
    int st, gap, gl;
    clear_events();
    hold(1'b1, 10);
    for (int i = 0; i < 8; i++) begin
      b   = 8'($urandom);
      gap = int'($urandom_range(0, 20));
      gl  = int'($urandom_range(W, 9 * W - 1));
      send_frame(b, 1'b1, gl, st);
      exp_dat.push_back(b);
      exp_cyc.push_back(st + LAT);
      hold(1'b1, gap);
    end
    hold(1'b1, 20);
    checks++; if (v_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", v_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < v_cyc.size(); i++) begin
      checks++; if (v_dat[i] !== exp_dat[i]) begin errors++; $display("FAIL rand_data%0d: got %h want %h", i, v_dat[i], exp_dat[i]); end
      checks++; if (v_cyc[i] !== exp_cyc[i]) begin errors++; $display("FAIL rand_time%0d: got %0d want %0d", i, v_cyc[i], exp_cyc[i]); end
    end
    checks++; if (f_cyc.size() !== 0) begin errors++; $display("FAIL rand_ferr: got %0d want 0", f_cyc.size()); end
  endtask

  task automatic test_protocol();
    checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_ferr();
    test_back_to_back();
    test_majority();
    test_reset_midframe();
    test_random();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
